// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package cpu_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    DLVR = 2'd2
  } fetch_state_e;

  localparam int unsigned PC_INC = 4;
  localparam logic [31:0] INIT_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/pc_reg_next.sv
// Program counter register with hold / +4 / redirect / pending-target mux.
module pc_reg_next
  import cpu_fetch_pkg::*;
#(
  parameter int              ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] INIT_PC = ADDR_W'(INIT_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_i,
  input  logic              redir_i,
  input  logic [ADDR_W-1:0] redir_tgt_i,
  input  logic              pend_i,
  input  logic [ADDR_W-1:0] pend_tgt_i,
  output logic [ADDR_W-1:0] pc_o
);

  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);

  logic [ADDR_W-1:0] pc_d, pc_q;

  // Selects are one-hot by construction in the controller.
  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      redir_i: pc_d = redir_tgt_i & ALIGN;
      pend_i:  pc_d = pend_tgt_i & ALIGN;
      inc_i:   pc_d = pc_q + ADDR_W'(PC_INC);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= INIT_PC & ALIGN;
    else        pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues single-outstanding imem
// requests and hands instructions to decode over valid/ready.
module pc_fetch_ctrl
  import cpu_fetch_pkg::*;
#(
  parameter int              ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] INIT_PC = ADDR_W'(INIT_PC_DEF),
  parameter int              INST_W  = 32,
  parameter int              CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [CNT_W-1:0]  fetch_count
);

  fetch_state_e      state_q, state_d;
  logic              kill_q, kill_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic              valid_q, valid_d;
  logic [INST_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              pc_inc, pc_redir, pc_pend;
  logic [ADDR_W-1:0] pc_w;

  pc_reg_next #(
    .ADDR_W  (ADDR_W),
    .INIT_PC (INIT_PC)
  ) u_pc (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc_i       (pc_inc),
    .redir_i     (pc_redir),
    .redir_tgt_i (redirect_target),
    .pend_i      (pc_pend),
    .pend_tgt_i  (pend_q),
    .pc_o        (pc_w)
  );

  always_comb begin
    state_d  = state_q;
    kill_d   = kill_q;
    pend_d   = pend_q;
    valid_d  = valid_q;
    data_d   = data_q;
    ipc_d    = ipc_q;
    cnt_d    = cnt_q;
    pc_inc   = 1'b0;
    pc_redir = 1'b0;
    pc_pend  = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d  = REQ;
        pc_redir = redirect_valid;
      end
      REQ: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            pc_redir = 1'b1;
            kill_d   = 1'b0;
          end else if (kill_q) begin
            pc_pend = 1'b1;
            kill_d  = 1'b0;
          end else begin
            data_d  = imem_rdata;
            ipc_d   = pc_w;
            valid_d = 1'b1;
            pc_inc  = 1'b1;
            state_d = DLVR;
          end
        end else if (redirect_valid) begin
          // Address stays put until the in-flight ack drains.
          pend_d = redirect_target;
          kill_d = 1'b1;
        end
      end
      DLVR: begin
        if (inst_ready) cnt_d = cnt_q + CNT_W'(1);
        if (redirect_valid) pc_redir = 1'b1;
        if (inst_ready || redirect_valid) begin
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign req_d = (state_d == REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      kill_q  <= 1'b0;
      pend_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ipc_q   <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ipc_q   <= ipc_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_w;
  assign pc          = pc_w;
  assign inst_valid  = valid_q;
  assign inst_data   = data_q;
  assign inst_pc     = ipc_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a fetch-transaction model.
module tb_pc_fetch_ctrl;

  localparam int CW = 4;
  localparam logic [31:0] K = 32'hA5A5_A5A5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          redirect_valid;
  logic [31:0]   redirect_target;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          inst_valid;
  logic [31:0]   inst_data;
  logic [31:0]   inst_pc;
  logic          inst_ready;
  logic [31:0]   pc;
  logic [CW-1:0] fetch_count;

  int cmp = 0;
  int errs = 0;
  int lat = 0;
  int wcnt = 0;
  logic stray = 1'b0;

  // Counter narrowed so the wrap point is reachable.
  pc_fetch_ctrl #(.CNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .inst_valid      (inst_valid),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready),
    .pc              (pc),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory: answers after lat wait cycles with addr ^ K.
  always @(posedge clk) begin
    #2;
    if (stray) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
    end else if (imem_req) begin
      if (wcnt == lat) begin
        imem_ack   = 1'b1;
        imem_rdata = imem_addr ^ K;
        wcnt       = 0;
      end else begin
        imem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wcnt     = 0;
    end
  end

  // Model: phase 0 bubble, 1 waiting on memory, 2 offering to decode.
  int          m_phase;
  logic [31:0] m_pc, m_data, m_ipc, m_after;
  logic        m_valid, m_doomed;
  int          m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_pc = 0; m_data = 0; m_ipc = 0;
      m_valid = 0; m_doomed = 0; m_after = 0; m_cnt = 0;
    end else if (m_phase == 0) begin
      if (redirect_valid) m_pc = {redirect_target[31:2], 2'b00};
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (imem_ack && redirect_valid) begin
        m_pc = {redirect_target[31:2], 2'b00};
        m_doomed = 0;
      end else if (imem_ack && m_doomed) begin
        m_pc = m_after;
        m_doomed = 0;
      end else if (imem_ack) begin
        m_data = imem_rdata; m_ipc = m_pc; m_valid = 1;
        m_pc = m_pc + 32'd4;
        m_phase = 2;
      end else if (redirect_valid) begin
        m_doomed = 1;
        m_after = {redirect_target[31:2], 2'b00};
      end
    end else begin
      if (inst_ready) m_cnt = (m_cnt + 1) % (1 << CW);
      if (redirect_valid) m_pc = {redirect_target[31:2], 2'b00};
      if (inst_ready || redirect_valid) begin
        m_valid = 0;
        m_phase = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("imem_req", {31'b0, imem_req}, {31'b0, m_phase == 1});
    chk("imem_addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
    chk("inst_data", inst_data, m_data);
    chk("inst_pc", inst_pc, m_ipc);
    chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_dlvr(input logic [31:0] a);
    for (int i = 0; i < 40; i++) begin
      if (inst_valid && inst_pc == a) return;
      step(1);
    end
    chk("wait_dlvr_timeout", inst_pc, a);
  endtask

  task automatic wait_req(input logic [31:0] a);
    for (int i = 0; i < 40; i++) begin
      if (imem_req && imem_addr == a) return;
      step(1);
    end
    chk("wait_req_timeout", imem_addr, a);
  endtask

  initial begin
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    inst_ready = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = '0;
    step(3);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_cnt", 32'(fetch_count), 32'd0);

    rst_n = 1'b1;
    chk("boot_no_req", {31'b0, imem_req}, 32'd0);
    step(1);
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    step(1);
    chk("first_valid", {31'b0, inst_valid}, 32'd1);
    chk("first_data", inst_data, K);

    wait_req(32'h8);
    inst_ready = 1'b0;
    step(1);
    chk("stall_pc", inst_pc, 32'h8);
    chk("stall_cnt", 32'(fetch_count), 32'd2);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("stall_hold_pc", inst_pc, 32'h8);
      chk("stall_hold_req", {31'b0, imem_req}, 32'd0);
    end
    inst_ready = 1'b1;
    step(1);
    chk("resume_addr", imem_addr, 32'hC);
    chk("resume_cnt", 32'(fetch_count), 32'd3);

    wait_dlvr(32'h10);
    chk("cnt_at_10", 32'(fetch_count), 32'd4);
    redirect_valid = 1'b1;
    redirect_target = 32'h203;
    step(1);
    redirect_valid = 1'b0;
    chk("redir_addr", imem_addr, 32'h200);
    chk("redir_cnt", 32'(fetch_count), 32'd5);
    lat = 3;

    wait_dlvr(32'h200);
    redirect_valid = 1'b1;
    redirect_target = 32'h4;
    step(1);
    redirect_valid = 1'b0;
    step(1);
    redirect_valid = 1'b1;
    redirect_target = 32'h100;
    step(1);
    redirect_valid = 1'b0;
    chk("kill_hold_addr", imem_addr, 32'h4);
    step(1);
    chk("kill_ack_addr", imem_addr, 32'h4);
    step(1);
    chk("kill_new_addr", imem_addr, 32'h100);
    chk("kill_no_valid", {31'b0, inst_valid}, 32'd0);
    lat = 0;
    wait_dlvr(32'h100);
    chk("kill_data", inst_data, 32'h100 ^ K);

    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    step(1);
    redirect_valid = 1'b0;
    step(1);
    chk("top_pc", inst_pc, 32'hFFFF_FFFC);
    step(1);
    chk("wrap_addr", imem_addr, 32'h0);

    for (int i = 0; i < 40; i++) begin
      if (fetch_count == '1) break;
      step(1);
    end
    for (int i = 0; i < 4; i++) begin
      if (fetch_count != '1) break;
      step(1);
    end
    chk("cnt_wrap", 32'(fetch_count), 32'd0);

    lat = 3;
    for (int i = 0; i < 10; i++) begin
      if (imem_req) break;
      step(1);
    end
    step(1);
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, imem_req}, 32'd0);
    chk("arst_pc", pc, 32'h0);
    chk("arst_valid", {31'b0, inst_valid}, 32'd0);
    chk("arst_ipc", inst_pc, 32'h0);
    chk("arst_data", inst_data, 32'h0);
    chk("arst_cnt", 32'(fetch_count), 32'd0);
    step(2);
    lat = 0;
    rst_n = 1'b1;
    stray = 1'b1;
    step(1);
    stray = 1'b0;
    chk("stray_req", {31'b0, imem_req}, 32'd1);
    chk("stray_valid", {31'b0, inst_valid}, 32'd0);
    chk("stray_addr", imem_addr, 32'h0);
    step(1);
    chk("restart_pc", inst_pc, 32'h0);
    chk("restart_data", inst_data, K);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
